// File: rtl/cmac_usplus_0_axis_tx_pkt_fifo.sv
// Store-and-forward packet FIFO feeding the CMAC TX AXIS port. A packet becomes
// visible to the read side only after its tlast beat is written and accepted.
module cmac_usplus_0_axis_tx_pkt_fifo #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter bit          DROP_ON_ERR = 1'b1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [511:0]          s_axis_tdata,
  input  logic [63:0]           s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [511:0]          m_axis_tdata,
  output logic [63:0]           m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [ADDR_WIDTH:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  drop_pulse
);

  localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
  localparam int unsigned ENTRY_W = 512 + 64 + 2;

  typedef logic [ADDR_WIDTH:0] ptr_t;
  typedef enum logic {WR_PASS, WR_DISCARD} wr_state_t;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] ram_q;
  logic               ram_valid;

  ptr_t      wr_ptr;
  ptr_t      wr_cur;
  ptr_t      rd_ptr;
  ptr_t      used;
  wr_state_t wr_state;

  logic s_hs;
  logic full;
  logic err_drop;
  logic mem_we;
  logic pkt_end;
  logic pkt_drop;
  logic pkt_commit;
  logic wr_user;

  logic out_ready;
  logic ram_move;
  logic rd_en;
  logic rd_last;

  assign s_hs       = s_axis_tvalid && s_axis_tready;
  assign used       = wr_cur - rd_ptr;
  assign full       = (used == ptr_t'(DEPTH));
  assign err_drop   = DROP_ON_ERR && s_axis_tuser;
  assign mem_we     = s_hs && (wr_state == WR_PASS) && !full;
  assign pkt_end    = s_hs && s_axis_tlast;
  assign pkt_drop   = pkt_end && ((wr_state == WR_DISCARD) || full || err_drop);
  assign pkt_commit = pkt_end && !pkt_drop;
  // Error flag lives only on the tlast beat and never survives when errored packets are dropped.
  assign wr_user    = !DROP_ON_ERR && s_axis_tuser && s_axis_tlast;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_cur[ADDR_WIDTH-1:0]] <= {wr_user, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_axis_tready <= 1'b0;
      wr_ptr        <= '0;
      wr_cur        <= '0;
      wr_state      <= WR_PASS;
      drop_pulse    <= 1'b0;
      drop_count    <= '0;
    end else begin
      s_axis_tready <= 1'b1;
      drop_pulse    <= pkt_drop;
      if (pkt_drop) begin
        wr_cur   <= wr_ptr;
        wr_state <= WR_PASS;
        if (drop_count != '1) begin
          drop_count <= drop_count + 1'b1;
        end
      end else begin
        if (mem_we) begin
          wr_cur <= wr_cur + 1'b1;
        end
        if (pkt_commit) begin
          wr_ptr <= wr_cur + 1'b1;
        end
        if (s_hs && (wr_state == WR_PASS) && full) begin
          wr_state <= WR_DISCARD;
        end
      end
    end
  end

  // Two-stage read pipe (RAM output + output register) keeps one beat per cycle with no bubbles.
  assign out_ready = !m_axis_tvalid || m_axis_tready;
  assign ram_move  = ram_valid && out_ready;
  assign rd_en     = (rd_ptr != wr_ptr) && (!ram_valid || ram_move);
  assign rd_last   = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_ff @(posedge clk) begin
    if (rd_en) begin
      ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr        <= '0;
      ram_valid     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      pkt_count     <= '0;
    end else begin
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      ram_valid <= rd_en || (ram_valid && !ram_move);
      if (out_ready) begin
        m_axis_tvalid <= ram_valid;
        if (ram_valid) begin
          {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= ram_q;
        end
      end
      case ({pkt_commit, rd_last})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule

// File: tb/tb_cmac_usplus_0_axis_tx_pkt_fifo.sv
// Bench for the CMAC TX packet FIFO: a 512-beat instance and a 16-beat instance
// share stimulus; a queue-based packet model predicts which packets emerge.
module tb_cmac_usplus_0_axis_tx_pkt_fifo;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic         user;
  } beat_t;

  localparam int DEPTH4 = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         s_valid = 1'b0;
  logic [511:0] s_data = '0;
  logic [63:0]  s_keep = '0;
  logic         s_last = 1'b0;
  logic         s_user = 1'b0;
  logic         m_ready = 1'b0;

  logic         d9_sready, d9_valid, d9_last, d9_user, d9_pulse;
  logic [511:0] d9_data;
  logic [63:0]  d9_keep;
  logic [9:0]   d9_pkt;
  logic [15:0]  d9_drop;

  logic         d4_sready, d4_valid, d4_last, d4_user, d4_pulse;
  logic [511:0] d4_data;
  logic [63:0]  d4_keep;
  logic [4:0]   d4_pkt;
  logic [15:0]  d4_drop;

  always #5 clk = ~clk;

  cmac_usplus_0_axis_tx_pkt_fifo #(.ADDR_WIDTH(9), .DROP_ON_ERR(1'b1), .CNT_WIDTH(16)) u_dut9 (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_valid), .s_axis_tready(d9_sready), .s_axis_tdata(s_data),
    .s_axis_tkeep(s_keep), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tvalid(d9_valid), .m_axis_tready(m_ready), .m_axis_tdata(d9_data),
    .m_axis_tkeep(d9_keep), .m_axis_tlast(d9_last), .m_axis_tuser(d9_user),
    .pkt_count(d9_pkt), .drop_count(d9_drop), .drop_pulse(d9_pulse)
  );

  cmac_usplus_0_axis_tx_pkt_fifo #(.ADDR_WIDTH(4), .DROP_ON_ERR(1'b1), .CNT_WIDTH(16)) u_dut4 (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_valid), .s_axis_tready(d4_sready), .s_axis_tdata(s_data),
    .s_axis_tkeep(s_keep), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tvalid(d4_valid), .m_axis_tready(m_ready), .m_axis_tdata(d4_data),
    .m_axis_tkeep(d4_keep), .m_axis_tlast(d4_last), .m_axis_tuser(d4_user),
    .pkt_count(d4_pkt), .drop_count(d4_drop), .drop_pulse(d4_pulse)
  );

  int checks = 0;
  int failures = 0;

  beat_t pkt_q[$];
  beat_t exp_q[$];
  beat_t rx9[$];
  beat_t rx4[$];
  int stall9, gap9, user9, vcyc9, pulse9;
  int stall4, gap4, user4, vcyc4, pulse4;

  beat_t cur9, cur4, prev9, prev4;
  logic  in_pkt9, in_pkt4, pstall9, pstall4;
  assign cur9 = {d9_data, d9_keep, d9_last, d9_user};
  assign cur4 = {d4_data, d4_keep, d4_last, d4_user};

  // Output observers: record accepted beats and count protocol violations.
  always @(negedge clk) begin
    if (reset) begin
      in_pkt9 = 1'b0; pstall9 = 1'b0;
    end else begin
      if (pstall9 && (!d9_valid || cur9 !== prev9)) stall9++;
      if (in_pkt9 && !d9_valid) gap9++;
      if (d9_valid) vcyc9++;
      if (d9_pulse) pulse9++;
      if (d9_valid && d9_user) user9++;
      if (d9_valid && m_ready) begin rx9.push_back(cur9); in_pkt9 = !d9_last; end
      pstall9 = d9_valid && !m_ready;
      prev9 = cur9;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      in_pkt4 = 1'b0; pstall4 = 1'b0;
    end else begin
      if (pstall4 && (!d4_valid || cur4 !== prev4)) stall4++;
      if (in_pkt4 && !d4_valid) gap4++;
      if (d4_valid) vcyc4++;
      if (d4_pulse) pulse4++;
      if (d4_valid && d4_user) user4++;
      if (d4_valid && m_ready) begin rx4.push_back(cur4); in_pkt4 = !d4_last; end
      pstall4 = d4_valid && !m_ready;
      prev4 = cur4;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clear_obs;
    rx9.delete(); rx4.delete(); exp_q.delete(); pkt_q.delete();
    stall9 = 0; gap9 = 0; user9 = 0; vcyc9 = 0; pulse9 = 0;
    stall4 = 0; gap4 = 0; user4 = 0; vcyc4 = 0; pulse4 = 0;
  endtask

  task automatic do_reset;
    s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    clear_obs();
  endtask

  // Model: a packet emerges unchanged (tuser cleared) unless errored or it cannot fit.
  task automatic build_pkt(input int nbeats, input logic err, input logic [63:0] last_keep, input bit ok);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      for (int w = 0; w < 16; w++) b.data[w*32 +: 32] = $urandom();
      b.last = (i == nbeats - 1);
      b.keep = b.last ? last_keep : '1;
      b.user = b.last ? err : 1'b0;
      pkt_q.push_back(b);
      if (ok) begin
        b.user = 1'b0;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic send_queued(input int gap_pct, input int nmax);
    beat_t b;
    for (int n = 0; n < nmax && pkt_q.size() > 0; n++) begin
      while ($urandom_range(99) < gap_pct) begin s_valid = 1'b0; tick(); end
      b = pkt_q.pop_front();
      s_valid = 1'b1; s_data = b.data; s_keep = b.keep; s_last = b.last; s_user = b.user;
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0;
  endtask

  task automatic ready_random(input int max_cycles);
    for (int c = 0; c < max_cycles && rx9.size() < exp_q.size(); c++) begin
      m_ready = 1'($urandom_range(1));
      tick();
    end
    m_ready = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) tick();
    checks++; if (d9_sready !== 1'b0) begin failures++; $display("FAIL rst_sready9 got=%b exp=0", d9_sready); end
    checks++; if (d4_sready !== 1'b0) begin failures++; $display("FAIL rst_sready4 got=%b exp=0", d4_sready); end
    checks++; if (d9_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", d9_valid); end
    checks++; if (d9_pkt !== 10'd0) begin failures++; $display("FAIL rst_pkt_count got=%0d exp=0", d9_pkt); end
    checks++; if (d9_drop !== 16'd0) begin failures++; $display("FAIL rst_drop_count got=%0d exp=0", d9_drop); end
    checks++; if (d9_data !== 512'd0 || d9_keep !== 64'd0) begin failures++; $display("FAIL rst_data got keep=%h exp=0", d9_keep); end
    reset = 1'b0;
    tick();
    checks++; if (d9_sready !== 1'b1) begin failures++; $display("FAIL rst_rise_sready9 got=%b exp=1", d9_sready); end
    checks++; if (d4_sready !== 1'b1) begin failures++; $display("FAIL rst_rise_sready4 got=%b exp=1", d4_sready); end
    clear_obs();
  endtask

  task automatic test_single_packet;
    beat_t b;
    int early = 0;
    do_reset();
    m_ready = 1'b1;
    build_pkt(9, 1'b0, 64'h3FF, 1'b1);
    while (pkt_q.size() > 0) begin
      b = pkt_q.pop_front();
      s_valid = 1'b1; s_data = b.data; s_keep = b.keep; s_last = b.last; s_user = b.user;
      @(negedge clk);
      if (d9_valid) early++;
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (early !== 0) begin failures++; $display("FAIL t1_early_valid got=%0d cycles exp=0", early); end
    tick(); tick();
    checks++; if (d9_valid !== 1'b1) begin failures++; $display("FAIL t1_latency valid_at_T+2 got=%b exp=1", d9_valid); end
    checks++; if (d9_pkt !== 10'd1) begin failures++; $display("FAIL t1_pkt_count_one got=%0d exp=1", d9_pkt); end
    for (int c = 0; c < 40 && rx9.size() < exp_q.size(); c++) tick();
    repeat (5) tick();
    checks++; if (rx9.size() !== exp_q.size()) begin failures++; $display("FAIL t1_beats got=%0d exp=%0d", rx9.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx9.size(); i++) begin
      checks++;
      if (rx9[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL t1_beat[%0d] got keep=%h last=%b data=%h exp keep=%h last=%b data=%h",
                 i, rx9[i].keep, rx9[i].last, rx9[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].data);
        break;
      end
    end
    checks++; if (vcyc9 !== 9 || gap9 !== 0) begin failures++; $display("FAIL t1_contiguous got valid_cycles=%0d gaps=%0d exp 9/0", vcyc9, gap9); end
    checks++; if (d9_pkt !== 10'd0) begin failures++; $display("FAIL t1_pkt_count_zero got=%0d exp=0", d9_pkt); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int p = 0; p < 3; p++) build_pkt(1, 1'b0, '1, 1'b1);
    fork
      send_queued(0, 1000);
      ready_random(400);
    join
    repeat (10) tick();
    checks++; if (rx9.size() !== 3) begin failures++; $display("FAIL t2_beats got=%0d exp=3", rx9.size()); end
    for (int i = 0; i < exp_q.size() && i < rx9.size(); i++) begin
      checks++;
      if (rx9[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL t2_beat[%0d] got data=%h exp data=%h", i, rx9[i].data, exp_q[i].data);
        break;
      end
    end
    checks++; if (stall9 !== 0) begin failures++; $display("FAIL t2_stall_stable got=%0d violations exp=0", stall9); end
    checks++; if (d9_drop !== 16'd0) begin failures++; $display("FAIL t2_drop_count got=%0d exp=0", d9_drop); end
  endtask

  task automatic test_random_stream;
    int drops = 0;
    int n;
    logic err;
    logic [63:0] lk;
    do_reset();
    for (int p = 0; p < 16; p++) begin
      err = ($urandom_range(3) == 0);
      n = $urandom_range(1, 64);
      lk = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
      build_pkt($urandom_range(1, 8), err, lk, !err);
      if (err) drops++;
    end
    fork
      send_queued(30, 1000);
      ready_random(3000);
    join
    repeat (10) tick();
    checks++; if (rx9.size() !== exp_q.size()) begin failures++; $display("FAIL rnd_beats got=%0d exp=%0d", rx9.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx9.size(); i++) begin
      checks++;
      if (rx9[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rnd_beat[%0d] got keep=%h last=%b user=%b exp keep=%h last=%b user=%b",
                 i, rx9[i].keep, rx9[i].last, rx9[i].user, exp_q[i].keep, exp_q[i].last, exp_q[i].user);
        break;
      end
    end
    checks++; if (d9_drop !== 16'(drops)) begin failures++; $display("FAIL rnd_drop_count got=%0d exp=%0d", d9_drop, drops); end
    checks++; if (pulse9 !== drops) begin failures++; $display("FAIL rnd_drop_pulses got=%0d exp=%0d", pulse9, drops); end
    checks++; if (stall9 !== 0 || gap9 !== 0) begin failures++; $display("FAIL rnd_protocol got stall=%0d gap=%0d exp 0/0", stall9, gap9); end
    checks++; if (d9_pkt !== 10'd0) begin failures++; $display("FAIL rnd_pkt_count got=%0d exp=0", d9_pkt); end
  endtask

  task automatic test_error_drop;
    do_reset();
    m_ready = 1'b1;
    build_pkt(3, 1'b1, '1, 1'b0);
    build_pkt(2, 1'b0, 64'hFFFF, 1'b1);
    send_queued(0, 1000);
    for (int c = 0; c < 40 && rx9.size() < exp_q.size(); c++) tick();
    repeat (10) tick();
    checks++; if (rx9.size() !== 2) begin failures++; $display("FAIL err_beats got=%0d exp=2", rx9.size()); end
    for (int i = 0; i < exp_q.size() && i < rx9.size(); i++) begin
      checks++;
      if (rx9[i] !== exp_q[i]) begin failures++; $display("FAIL err_beat[%0d] got data=%h exp data=%h", i, rx9[i].data, exp_q[i].data); break; end
    end
    checks++; if (d9_drop !== 16'd1) begin failures++; $display("FAIL err_drop_count got=%0d exp=1", d9_drop); end
    checks++; if (pulse9 !== 1) begin failures++; $display("FAIL err_drop_pulse got=%0d cycles exp=1", pulse9); end
    checks++; if (user9 !== 0) begin failures++; $display("FAIL err_tuser got=%0d beats exp=0", user9); end
  endtask

  task automatic test_overflow;
    int used_beats = 0;
    bit fits;
    do_reset();
    m_ready = 1'b0;
    fits = (used_beats + 10 <= DEPTH4);
    build_pkt(10, 1'b0, '1, fits);
    if (fits) used_beats += 10;
    fits = (used_beats + 10 <= DEPTH4);
    build_pkt(10, 1'b0, '1, fits);
    send_queued(0, 1000);
    repeat (5) tick();
    checks++; if (d4_pkt !== 5'd1) begin failures++; $display("FAIL ovf_pkt_count got=%0d exp=1", d4_pkt); end
    checks++; if (d4_drop !== 16'd1) begin failures++; $display("FAIL ovf_drop_count got=%0d exp=1", d4_drop); end
    checks++; if (pulse4 !== 1) begin failures++; $display("FAIL ovf_drop_pulse got=%0d exp=1", pulse4); end
    m_ready = 1'b1;
    for (int c = 0; c < 60 && rx4.size() < exp_q.size(); c++) tick();
    repeat (10) tick();
    checks++; if (rx4.size() !== 10) begin failures++; $display("FAIL ovf_beats got=%0d exp=10", rx4.size()); end
    for (int i = 0; i < exp_q.size() && i < rx4.size(); i++) begin
      checks++;
      if (rx4[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_beat[%0d] got data=%h exp data=%h", i, rx4[i].data, exp_q[i].data); break; end
    end
    checks++; if (d4_pkt !== 5'd0) begin failures++; $display("FAIL ovf_pkt_count_end got=%0d exp=0", d4_pkt); end
  endtask

  task automatic test_oversize;
    do_reset();
    m_ready = 1'b1;
    build_pkt(20, 1'b0, '1, (20 <= DEPTH4));
    send_queued(0, 1000);
    repeat (6) tick();
    checks++; if (vcyc4 !== 0) begin failures++; $display("FAIL big_no_valid got=%0d cycles exp=0", vcyc4); end
    checks++; if (d4_drop !== 16'd1) begin failures++; $display("FAIL big_drop_count got=%0d exp=1", d4_drop); end
    build_pkt(3, 1'b0, 64'hFF, 1'b1);
    send_queued(0, 1000);
    for (int c = 0; c < 40 && rx4.size() < exp_q.size(); c++) tick();
    repeat (10) tick();
    checks++; if (rx4.size() !== exp_q.size()) begin failures++; $display("FAIL big_after_beats got=%0d exp=%0d", rx4.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx4.size(); i++) begin
      checks++;
      if (rx4[i] !== exp_q[i]) begin failures++; $display("FAIL big_after_beat[%0d] got data=%h exp data=%h", i, rx4[i].data, exp_q[i].data); break; end
    end
  endtask

  task automatic test_reset_mid_packet;
    do_reset();
    m_ready = 1'b1;
    build_pkt(12, 1'b0, '1, 1'b0);
    build_pkt(8, 1'b0, '1, 1'b0);
    send_queued(0, 12);
    send_queued(0, 4);
    checks++; if (d9_valid !== 1'b1) begin failures++; $display("FAIL mid_reading got valid=%b exp=1", d9_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (d9_sready !== 1'b0 || d9_valid !== 1'b0 || d9_last !== 1'b0 || d9_user !== 1'b0 || d9_pulse !== 1'b0)
      begin failures++; $display("FAIL mid_rst_ctrl got sready=%b valid=%b last=%b user=%b pulse=%b exp all 0", d9_sready, d9_valid, d9_last, d9_user, d9_pulse); end
    checks++; if (d9_data !== 512'd0 || d9_keep !== 64'd0) begin failures++; $display("FAIL mid_rst_data got keep=%h exp=0", d9_keep); end
    checks++; if (d9_pkt !== 10'd0 || d9_drop !== 16'd0) begin failures++; $display("FAIL mid_rst_counts got pkt=%0d drop=%0d exp 0/0", d9_pkt, d9_drop); end
    tick();
    checks++; if (d9_sready !== 1'b1) begin failures++; $display("FAIL mid_rst_sready got=%b exp=1", d9_sready); end
    clear_obs();
    build_pkt(2, 1'b0, 64'hF, 1'b1);
    send_queued(0, 1000);
    for (int c = 0; c < 40 && rx9.size() < exp_q.size(); c++) tick();
    repeat (10) tick();
    checks++; if (rx9.size() !== 2) begin failures++; $display("FAIL mid_fresh_beats got=%0d exp=2", rx9.size()); end
    for (int i = 0; i < exp_q.size() && i < rx9.size(); i++) begin
      checks++;
      if (rx9[i] !== exp_q[i]) begin failures++; $display("FAIL mid_fresh_beat[%0d] got data=%h exp data=%h", i, rx9[i].data, exp_q[i].data); break; end
    end
    checks++; if (d9_pkt !== 10'd0) begin failures++; $display("FAIL mid_pkt_count got=%0d exp=0", d9_pkt); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_random_stream();
    test_error_drop();
    test_overflow();
    test_oversize();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
